// File: rtl/countdown_timer_prog.sv
// Programmable countdown timer: load/start/pause/clear control, prescaled tick, optional auto-reload.
// Define TIMER_WARN_EN to build the registered near-expiry warn output (tied to 0 otherwise).
module countdown_timer_prog #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned PRESCALE   = 50000000,
    parameter int unsigned WARN_LEVEL = 5
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_clear,
    input  logic             i_auto_reload,
    input  logic [WIDTH-1:0] i_sw_time,
    output logic [WIDTH-1:0] o_time_set,
    output logic [WIDTH-1:0] o_time_left,
    output logic             o_running,
    output logic             o_done,
    output logic             o_done_pulse,
    output logic             o_tick,
    output logic             o_warn
);

    localparam int unsigned   PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOADED  = 3'd1;
    localparam logic [2:0] ST_RUNNING = 3'd2;
    localparam logic [2:0] ST_PAUSED  = 3'd3;
    localparam logic [2:0] ST_EXPIRED = 3'd4;

    // Threshold must fit in the count width, and the prescaler needs at least one cycle.
    if (PRESCALE < 1 || (64'(WARN_LEVEL) >> WIDTH) != 64'd0) begin : g_bad_param
        $error("countdown_timer_prog: PRESCALE must be >= 1 and WARN_LEVEL must fit in WIDTH");
    end

    logic [2:0]       r_state;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_time_set;
    logic [WIDTH-1:0] r_time_left;
    logic             r_done_pulse;

    logic [2:0]       w_state_d;
    logic [PW-1:0]    w_presc_d;
    logic [WIDTH-1:0] w_time_set_d;
    logic [WIDTH-1:0] w_time_left_d;
    logic             w_done_pulse_d;
    logic             w_tick;

    assign w_tick = (r_state == ST_RUNNING) && (r_presc == PRESC_MAX);

    always_comb begin
        w_state_d      = r_state;
        w_presc_d      = r_presc;
        w_time_set_d   = r_time_set;
        w_time_left_d  = r_time_left;
        w_done_pulse_d = 1'b0;
        if (i_clear) begin
            w_state_d     = ST_IDLE;
            w_time_left_d = '0;
            w_presc_d     = '0;
        end else if (i_load) begin
            w_state_d     = ST_LOADED;
            w_time_set_d  = i_sw_time;
            w_time_left_d = i_sw_time;
            w_presc_d     = '0;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_LOADED: begin
                    if (i_start) begin
                        w_presc_d = '0;
                        if (r_time_left == '0) begin
                            w_state_d      = ST_EXPIRED;
                            w_done_pulse_d = 1'b1;
                        end else begin
                            w_state_d = ST_RUNNING;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (i_start) begin
                        w_state_d = ST_RUNNING;
                    end
                end
                ST_EXPIRED: begin
                    if (i_start) begin
                        w_presc_d = '0;
                        // A zero reload value expires again instead of running a zero-length count.
                        if (r_time_set == '0) begin
                            w_time_left_d  = '0;
                            w_done_pulse_d = 1'b1;
                        end else begin
                            w_time_left_d = r_time_set;
                            w_state_d     = ST_RUNNING;
                        end
                    end
                end
                ST_RUNNING: begin
                    if (i_pause) begin
                        w_state_d = ST_PAUSED;
                    end else if (w_tick) begin
                        w_presc_d = '0;
                        if (r_time_left > WIDTH'(1)) begin
                            w_time_left_d = r_time_left - WIDTH'(1);
                        end else begin
                            w_done_pulse_d = 1'b1;
                            if (i_auto_reload && (r_time_set != '0)) begin
                                w_time_left_d = r_time_set;
                            end else begin
                                w_time_left_d = '0;
                                w_state_d     = ST_EXPIRED;
                            end
                        end
                    end else begin
                        w_presc_d = r_presc + PW'(1);
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_time_set   <= '0;
            r_time_left  <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_presc      <= w_presc_d;
            r_time_set   <= w_time_set_d;
            r_time_left  <= w_time_left_d;
            r_done_pulse <= w_done_pulse_d;
        end
    end

    assign o_time_set   = r_time_set;
    assign o_time_left  = r_time_left;
    assign o_running    = (r_state == ST_RUNNING);
    assign o_done       = (r_state == ST_EXPIRED);
    assign o_done_pulse = r_done_pulse;
    assign o_tick       = w_tick;

`ifdef TIMER_WARN_EN
    localparam logic [WIDTH-1:0] WARN_THR = WIDTH'(WARN_LEVEL);
    logic r_warn;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_warn <= 1'b0;
        end else begin
            r_warn <= ((w_state_d == ST_RUNNING) || (w_state_d == ST_PAUSED)) &&
                      (w_time_left_d != '0) && (w_time_left_d <= WARN_THR);
        end
    end

    assign o_warn = r_warn;
`else
    assign o_warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer_prog.sv
// Scoreboard bench for countdown_timer_prog: a PRESCALE=4 instance and a PRESCALE=1 instance.
module tb_countdown_timer_prog;

    localparam int unsigned W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         load4, start4, pause4, clear4, ar4;
    logic [W-1:0] sw4, set4, left4;
    logic         run4, done4, dp4, tick4, warn4;
    logic         load1, start1, pause1, clear1, ar1;
    logic [W-1:0] sw1, set1, left1;
    logic         run1, done1, dp1, tick1, warn1;

    countdown_timer_prog #(.WIDTH(W), .PRESCALE(4), .WARN_LEVEL(2)) u_dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_load(load4), .i_start(start4), .i_pause(pause4),
        .i_clear(clear4), .i_auto_reload(ar4), .i_sw_time(sw4), .o_time_set(set4),
        .o_time_left(left4), .o_running(run4), .o_done(done4), .o_done_pulse(dp4),
        .o_tick(tick4), .o_warn(warn4)
    );

    countdown_timer_prog #(.WIDTH(W), .PRESCALE(1), .WARN_LEVEL(2)) u_dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_load(load1), .i_start(start1), .i_pause(pause1),
        .i_clear(clear1), .i_auto_reload(ar1), .i_sw_time(sw1), .o_time_set(set1),
        .o_time_left(left1), .o_running(run1), .o_done(done1), .o_done_pulse(dp1),
        .o_tick(tick1), .o_warn(warn1)
    );

    typedef struct {
        int           cyc;
        logic [W-1:0] val;
        logic         flag;
    } ev_t;

    ev_t tick_q[$];
    ev_t pulse_q[$];
    ev_t cyc_q[$];
    int  t_run  = 0;
    int  t_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load4(input logic [W-1:0] v);
        sw4 = v; load4 = 1'b1; step(); load4 = 1'b0;
    endtask

    task automatic pulse_start4();
        start4 = 1'b1; step(); start4 = 1'b0;
    endtask

    task automatic pulse_clear4();
        clear4 = 1'b1; step(); clear4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {load4, start4, pause4, clear4, ar4} = '0; sw4 = '0;
        {load1, start1, pause1, clear1, ar1} = '0; sw1 = '0;
        repeat (3) step();
        t_run++;
        if ({set4, left4, run4, done4, dp4, tick4, warn4} !== '0) begin
            t_fail++;
            $display("FAIL reset_dut4: got %h required 0", {set4, left4, run4, done4, dp4, tick4, warn4});
        end
        t_run++;
        if ({set1, left1, run1, done1, dp1, tick1, warn1} !== '0) begin
            t_fail++;
            $display("FAIL reset_dut1: got %h required 0", {set1, left1, run1, done1, dp1, tick1, warn1});
        end
        rst_n = 1'b1;
        step();
        t_run++;
        if ({run4, done4, tick4, left4} !== '0) begin
            t_fail++;
            $display("FAIL idle_after_reset: got %h required 0", {run4, done4, tick4, left4});
        end
    endtask

    task automatic test_countdown();
        ev_t e;
        drive_load4(6'd3);
        t_run++;
        if (left4 !== 6'd3 || set4 !== 6'd3 || run4 !== 1'b0) begin
            t_fail++;
            $display("FAIL load3: got left=%0d set=%0d run=%b required 3 3 0", left4, set4, run4);
        end
        tick_q.delete(); pulse_q.delete();
        tick_q.push_back('{cyc: 3, val: 6'd3, flag: 1'b0});
        tick_q.push_back('{cyc: 7, val: 6'd2, flag: 1'b0});
        tick_q.push_back('{cyc: 11, val: 6'd1, flag: 1'b0});
        pulse_q.push_back('{cyc: 12, val: 6'd0, flag: 1'b0});
        pulse_start4();
        for (int n = 0; n < 20; n++) begin
            if (tick4) begin
                t_run++;
                if (tick_q.size() == 0) begin
                    t_fail++;
                    $display("FAIL countdown_tick: unexpected tick at cycle %0d", n);
                end else begin
                    e = tick_q.pop_front();
                    if (n !== e.cyc || left4 !== e.val) begin
                        t_fail++;
                        $display("FAIL countdown_tick: got cyc=%0d left=%0d required cyc=%0d left=%0d",
                                 n, left4, e.cyc, e.val);
                    end
                end
            end
            if (dp4) begin
                t_run++;
                if (pulse_q.size() == 0) begin
                    t_fail++;
                    $display("FAIL countdown_pulse: unexpected done_pulse at cycle %0d", n);
                end else begin
                    e = pulse_q.pop_front();
                    if (n !== e.cyc || left4 !== e.val || done4 !== 1'b1) begin
                        t_fail++;
                        $display("FAIL countdown_pulse: got cyc=%0d left=%0d done=%b required cyc=%0d left=%0d done=1",
                                 n, left4, done4, e.cyc, e.val);
                    end
                end
            end
            step();
        end
        t_run++;
        if (tick_q.size() != 0 || pulse_q.size() != 0) begin
            t_fail++;
            $display("FAIL countdown_missing: got %0d ticks %0d pulses outstanding required 0 0",
                     tick_q.size(), pulse_q.size());
        end
        t_run++;
        if ({done4, run4, left4} !== {1'b1, 1'b0, 6'd0}) begin
            t_fail++;
            $display("FAIL countdown_end: got done=%b run=%b left=%0d required 1 0 0", done4, run4, left4);
        end
        pulse_clear4();
        t_run++;
        if ({done4, left4, set4} !== {1'b0, 6'd0, 6'd3}) begin
            t_fail++;
            $display("FAIL clear_after_expiry: got done=%b left=%0d set=%0d required 0 0 3", done4, left4, set4);
        end
    endtask

    task automatic test_pause();
        ev_t e;
        drive_load4(6'd5);
        pulse_start4();
        repeat (6) step();
        t_run++;
        if (left4 !== 6'd4 || tick4 !== 1'b0) begin
            t_fail++;
            $display("FAIL pause_setup: got left=%0d tick=%b required 4 0", left4, tick4);
        end
        pause4 = 1'b1; step(); pause4 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            t_run++;
            if (left4 !== 6'd4 || run4 !== 1'b0 || tick4 !== 1'b0 || done4 !== 1'b0) begin
                t_fail++;
                $display("FAIL pause_hold: cycle %0d got left=%0d run=%b tick=%b required 4 0 0",
                         k, left4, run4, tick4);
            end
            step();
        end
        tick_q.delete();
        tick_q.push_back('{cyc: 1, val: 6'd4, flag: 1'b0});
        tick_q.push_back('{cyc: 5, val: 6'd3, flag: 1'b0});
        pulse_start4();
        for (int r = 0; r < 7; r++) begin
            if (tick4) begin
                t_run++;
                if (tick_q.size() == 0) begin
                    t_fail++;
                    $display("FAIL resume_tick: unexpected tick at cycle %0d", r);
                end else begin
                    e = tick_q.pop_front();
                    if (r !== e.cyc || left4 !== e.val) begin
                        t_fail++;
                        $display("FAIL resume_tick: got cyc=%0d left=%0d required cyc=%0d left=%0d",
                                 r, left4, e.cyc, e.val);
                    end
                end
            end
            step();
        end
        t_run++;
        if (tick_q.size() != 0 || left4 !== 6'd2) begin
            t_fail++;
            $display("FAIL resume_end: got outstanding=%0d left=%0d required 0 2", tick_q.size(), left4);
        end
        pulse_clear4();
    endtask

    task automatic test_auto_reload();
        ev_t e;
        ar1 = 1'b1;
        sw1 = 6'd2; load1 = 1'b1; step(); load1 = 1'b0;
        cyc_q.delete();
        for (int n = 0; n < 10; n++) begin
            cyc_q.push_back('{cyc: n, val: (n % 2 == 0) ? 6'd2 : 6'd1,
                              flag: (n >= 2 && n % 2 == 0)});
        end
        start1 = 1'b1; step(); start1 = 1'b0;
        while (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            t_run++;
            if (left1 !== e.val || dp1 !== e.flag || done1 !== 1'b0 || run1 !== 1'b1 ||
                tick1 !== 1'b1) begin
                t_fail++;
                $display("FAIL auto_reload: cycle %0d got left=%0d pulse=%b done=%b run=%b tick=%b required %0d %b 0 1 1",
                         e.cyc, left1, dp1, done1, run1, tick1, e.val, e.flag);
            end
            step();
        end
        clear1 = 1'b1; ar1 = 1'b0; step(); clear1 = 1'b0;
    endtask

    task automatic test_zero_load();
        drive_load4(6'd0);
        pulse_start4();
        t_run++;
        if ({done4, dp4, run4, left4} !== {1'b1, 1'b1, 1'b0, 6'd0}) begin
            t_fail++;
            $display("FAIL zero_start: got done=%b pulse=%b run=%b left=%0d required 1 1 0 0",
                     done4, dp4, run4, left4);
        end
        step();
        t_run++;
        if (dp4 !== 1'b0 || done4 !== 1'b1) begin
            t_fail++;
            $display("FAIL zero_pulse_width: got pulse=%b done=%b required 0 1", dp4, done4);
        end
        pulse_start4();
        t_run++;
        if ({done4, dp4, run4, left4} !== {1'b1, 1'b1, 1'b0, 6'd0}) begin
            t_fail++;
            $display("FAIL zero_restart: got done=%b pulse=%b run=%b left=%0d required 1 1 0 0",
                     done4, dp4, run4, left4);
        end
        step();
        t_run++;
        if (dp4 !== 1'b0) begin
            t_fail++;
            $display("FAIL zero_restart_width: got pulse=%b required 0", dp4);
        end
        pulse_clear4();
    endtask

    task automatic test_clear_load();
        drive_load4(6'd9);
        pulse_start4();
        for (int k = 0; k < 40 && left4 !== 6'd7; k++) step();
        t_run++;
        if (left4 !== 6'd7 || run4 !== 1'b1) begin
            t_fail++;
            $display("FAIL reach_7: got left=%0d run=%b required 7 1", left4, run4);
        end
        sw4 = 6'd20; load4 = 1'b1; clear4 = 1'b1; step(); load4 = 1'b0; clear4 = 1'b0;
        t_run++;
        if ({run4, done4, left4, set4} !== {1'b0, 1'b0, 6'd0, 6'd9}) begin
            t_fail++;
            $display("FAIL clear_over_load: got run=%b done=%b left=%0d set=%0d required 0 0 0 9",
                     run4, done4, left4, set4);
        end
    endtask

    task automatic test_reset_mid();
        drive_load4(6'd1);
        pulse_start4();
        repeat (3) step();
        t_run++;
        if (run4 !== 1'b1 || tick4 !== 1'b1) begin
            t_fail++;
            $display("FAIL pre_reset: got run=%b tick=%b required 1 1", run4, tick4);
        end
        #2 rst_n = 1'b0;
        #1;
        t_run++;
        if ({set4, left4, run4, done4, dp4, tick4, warn4} !== '0) begin
            t_fail++;
            $display("FAIL reset_async: got %h required 0", {set4, left4, run4, done4, dp4, tick4, warn4});
        end
        step();
        t_run++;
        if ({dp4, done4, run4, left4} !== '0) begin
            t_fail++;
            $display("FAIL reset_no_pulse: got %h required 0", {dp4, done4, run4, left4});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_warn();
        ev_t e;
        logic [W-1:0] lv;
        cyc_q.delete();
        for (int n = 0; n < 20; n++) begin
            lv = (n < 4) ? 6'd4 : (n < 8) ? 6'd3 : (n < 12) ? 6'd2 : (n < 16) ? 6'd1 : 6'd0;
`ifdef TIMER_WARN_EN
            cyc_q.push_back('{cyc: n, val: lv, flag: (n >= 8 && n < 16)});
`else
            cyc_q.push_back('{cyc: n, val: lv, flag: 1'b0});
`endif
        end
        drive_load4(6'd4);
        pulse_start4();
        while (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            t_run++;
            if (left4 !== e.val || warn4 !== e.flag) begin
                t_fail++;
                $display("FAIL warn: cycle %0d got left=%0d warn=%b required %0d %b",
                         e.cyc, left4, warn4, e.val, e.flag);
            end
            step();
        end
        pulse_clear4();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_auto_reload();
        test_zero_load();
        test_clear_load();
        test_reset_mid();
        test_warn();
        $display("[TB] %0d tests run, %0d failed", t_run, t_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer_prog.md
Name: countdown_timer_prog

Overview:
Parametrised successor to the team's basic countdown timer. Holds a programmed start value and counts it down once per prescaled tick. Adds start/pause/resume control, an explicit state machine, optional auto-reload and a one-cycle expiry pulse. Sits between the switch/button front end and the display/alarm logic of the timer design.

Parameters:
WIDTH, 6, bit width of sw_time, time_set and time_left
PRESCALE, 50000000, clk cycles per countdown tick; must be >= 1
WARN_LEVEL, 5, threshold for warn output; used only with TIMER_WARN_EN

Ports:
clk  input  1  system clock; all state changes on rising edge
reset_n  input  1  asynchronous, active-low reset
load  input  1  capture sw_time into time_set and time_left
start  input  1  start, or resume from pause
pause  input  1  pause a running count
clear  input  1  abort the count and return to IDLE
auto_reload  input  1  1 = reload time_set on expiry and keep running
sw_time  input  WIDTH  programmed start value
time_set  output  WIDTH  last loaded value
time_left  output  WIDTH  remaining count
running  output  1  high while in RUNNING
done  output  1  level; high while in EXPIRED
done_pulse  output  1  one-cycle strobe on every expiry, including auto-reload expiries
tick  output  1  one-cycle strobe on every prescaler wrap while RUNNING
warn  output  1  see Optional Feature

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; prescaler = 0; all outputs = 0.
- States: IDLE, LOADED, RUNNING, PAUSED, EXPIRED.
- Control priority in any state: clear > load > pause > start.
- clear (any state): go to IDLE; time_left = 0; prescaler = 0; done = 0; time_set is retained.
- load (any state except when clear is also high): time_set and time_left both take sw_time on the same edge; prescaler = 0; done = 0; go to LOADED.
- start:
  - LOADED -> RUNNING. If time_left == 0 at that edge, go directly to EXPIRED instead, with done_pulse = 1 on the next cycle.
  - PAUSED -> RUNNING; the prescaler value is preserved, so no tick is lost or added.
  - EXPIRED -> RUNNING with time_left = time_set and prescaler = 0.
  - Ignored in IDLE and RUNNING.
- pause: RUNNING -> PAUSED; ignored in all other states. pause and start high together in RUNNING: pause wins.
- Prescaler: counts 0..PRESCALE-1 only while RUNNING. On the cycle it equals PRESCALE-1 it wraps to 0 and tick = 1 for that cycle. First tick arrives PRESCALE cycles after entering RUNNING from LOADED. PRESCALE = 1: tick is high every RUNNING cycle.
- On tick with time_left > 1: decrement time_left by 1.
- On tick with time_left == 1 (expiry): done_pulse = 1 the following cycle, then:
  - auto_reload = 1: time_left = time_set; stay RUNNING; done stays 0.
  - auto_reload = 0: time_left = 0; go to EXPIRED; done = 1.
  - Auto-reload with time_set == 0: time_left = 0, go to EXPIRED, done = 1 (no infinite zero loop).
- time_left never wraps below 0. Width is WIDTH bits unsigned; maximum load is 2^WIDTH-1.
- Outputs are registered. running, done and tick reflect state and prescaler registers with no combinational path from inputs.
- reset_n asserted mid-count: immediate return to reset values, with no done_pulse.

Optional Feature:
- Macro: TIMER_WARN_EN.
- Defined: warn = 1 while state is RUNNING or PAUSED and 0 < time_left <= WARN_LEVEL. warn is registered, updates on the same edge as time_left, and is 0 in all other states.
- Not defined: warn is tied to 0; no comparator or register is built.

Test Plan:
- PRESCALE=4, load sw_time=3, start -> ticks at 4, 8, 12 cycles after start; time_left goes 3,2,1,0; done = 1 and done_pulse high for exactly 1 cycle after the third tick; running = 0.
- PRESCALE=4, sw_time=5, start; pause 2 cycles into the second tick period; hold 10 cycles; start -> time_left stays 4 during pause; next tick arrives 2 cycles after resume.
- auto_reload=1, sw_time=2, PRESCALE=1 -> time_left sequence 2,1,2,1,...; done_pulse every 2 cycles; done stays 0.
- load sw_time=0, then start -> EXPIRED, done = 1, one done_pulse; a following start with time_set=0 re-expires.
- load and clear in the same cycle while RUNNING at time_left=7 -> IDLE, time_left = 0, time_set unchanged. Assert reset_n low mid-count -> all outputs 0 immediately, no done_pulse.
- TIMER_WARN_EN defined, WARN_LEVEL=2, sw_time=4 -> warn rises when time_left = 2, stays high at 1, falls at expiry; without the macro warn is constant 0.
